// File: rtl/wb_arbiter_if.sv
// Writeback bus between the FU result ports, the redirect source and the PRF write side.
// The redirect and exe bundles are carried as flat per-field signals.
interface wb_arbiter_if #(
   parameter int unsigned Nsrc = 4,
   parameter int unsigned Ewd  = 2
);
   logic [Nsrc-1:0]       src_valid;
   logic [Nsrc-1:0]       src_ready;
   logic [Nsrc-1:0][15:0] src_opid;
   logic [Nsrc-1:0][15:0] src_prda;
   logic [Nsrc-1:0][63:0] src_prdv;
   logic [15:0]           red_opid;
   logic [15:0]           red_topid;
   logic [Ewd-1:0][15:0]  exe_opid;
   logic [Ewd-1:0][15:0]  exe_prda;
   logic [Ewd-1:0][63:0]  exe_prdv;

   modport master (
      output src_valid, src_opid, src_prda, src_prdv, red_opid, red_topid,
      input  src_ready, exe_opid, exe_prda, exe_prdv
   );

   modport slave (
      input  src_valid, src_opid, src_prda, src_prdv, red_opid, red_topid,
      output src_ready, exe_opid, exe_prda, exe_prdv
   );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source result FIFOs, round-robin selection of up to Ewd results
// per cycle into a registered exe bundle, with redirect squashing of younger results.
module wb_arbiter #(
   parameter int unsigned Nsrc  = 4,
   parameter int unsigned Ewd   = 2,
   parameter int unsigned Depth = 4,
   parameter int unsigned Prnum = 128,
   parameter int unsigned Opsz  = 32
) (
   input logic         clk,
   input logic         rst,
   wb_arbiter_if.slave bus
);
   localparam int unsigned Aw = $clog2(Depth);
   localparam int unsigned Iw = $clog2(Opsz);
   localparam int unsigned Pw = $clog2(Prnum);
   localparam int unsigned Sw = $clog2(Nsrc);

   // Age relative to the oldest in-flight op; modular so ROB wrap is handled.
   function automatic logic succeed(logic [15:0] op, logic [15:0] red, logic [15:0] top);
      logic [Iw-1:0] d_op;
      logic [Iw-1:0] d_red;
      d_op  = op[Iw-1:0] - top[Iw-1:0];
      d_red = red[Iw-1:0] - top[Iw-1:0] + 1'b1;
      return red[15] & op[15] & (d_op >= d_red);
   endfunction

   logic [15:0]    opid_q [Nsrc][Depth];
   logic [Pw-1:0]  prda_q [Nsrc][Depth];
   logic [63:0]    prdv_q [Nsrc][Depth];
   logic [Depth-1:0] kill_q [Nsrc];
   logic [Depth-1:0] kill_d [Nsrc];
   logic [Aw-1:0]  wptr_q [Nsrc];
   logic [Aw-1:0]  rptr_q [Nsrc];
   logic [Aw:0]    cnt_q  [Nsrc];
   logic [Aw:0]    cnt_d  [Nsrc];
   logic [Sw-1:0]  rr_q, rr_d;

   logic [15:0]    head_opid [Nsrc];
   logic [Nsrc-1:0] live, dead, grant, pop, store;

   logic [Ewd-1:0][15:0] slot_opid, exe_opid_q;
   logic [Ewd-1:0][15:0] slot_prda, exe_prda_q;
   logic [Ewd-1:0][63:0] slot_prdv, exe_prdv_q;

   always_comb begin
      for (int s = 0; s < Nsrc; s++) begin
         head_opid[s] = opid_q[s][rptr_q[s]];
         dead[s]  = (cnt_q[s] != '0) & kill_q[s][rptr_q[s]];
         live[s]  = (cnt_q[s] != '0) & ~kill_q[s][rptr_q[s]] &
                    ~succeed(head_opid[s], bus.red_opid, bus.red_topid);
         store[s] = bus.src_valid[s] & bus.src_ready[s] & bus.src_opid[s][15] &
                    (bus.src_prda[s][Pw-1:0] != '0) &
                    ~succeed(bus.src_opid[s], bus.red_opid, bus.red_topid);
      end
   end

   always_comb begin
      int unsigned n_gnt;
      n_gnt     = 0;
      grant     = '0;
      rr_d      = rr_q;
      slot_opid = '0;
      slot_prda = '0;
      slot_prdv = '0;
      for (int i = 0; i < Nsrc; i++) begin
         for (int s = 0; s < Nsrc; s++) begin
            if (((int'(rr_q) + i) % Nsrc == s) && live[s] && (n_gnt < Ewd)) begin
               grant[s] = 1'b1;
               for (int k = 0; k < Ewd; k++) begin
                  if (k == n_gnt) begin
                     slot_opid[k] = head_opid[s];
                     slot_prda[k] = 16'(prda_q[s][rptr_q[s]]);
                     slot_prdv[k] = prdv_q[s][rptr_q[s]];
                  end
               end
               n_gnt = n_gnt + 1;
               rr_d  = Sw'((s + 1) % Nsrc);
            end
         end
      end
   end

   always_comb begin
      for (int s = 0; s < Nsrc; s++) begin
         pop[s]   = grant[s] | dead[s];
         cnt_d[s] = cnt_q[s] + (Aw+1)'(store[s]) - (Aw+1)'(pop[s]);
         for (int e = 0; e < Depth; e++) begin
            kill_d[s][e] = kill_q[s][e] | succeed(opid_q[s][e], bus.red_opid, bus.red_topid);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q       <= '0;
         exe_opid_q <= '0;
         exe_prda_q <= '0;
         exe_prdv_q <= '0;
         for (int s = 0; s < Nsrc; s++) begin
            cnt_q[s]  <= '0;
            wptr_q[s] <= '0;
            rptr_q[s] <= '0;
            kill_q[s] <= '0;
         end
      end else begin
         rr_q       <= rr_d;
         exe_opid_q <= slot_opid;
         exe_prda_q <= slot_prda;
         exe_prdv_q <= slot_prdv;
         for (int s = 0; s < Nsrc; s++) begin
            cnt_q[s]  <= cnt_d[s];
            kill_q[s] <= kill_d[s];
            if (store[s]) begin
               kill_q[s][wptr_q[s]] <= 1'b0;
               wptr_q[s]            <= wptr_q[s] + 1'b1;
            end
            if (pop[s]) rptr_q[s] <= rptr_q[s] + 1'b1;
         end
      end
   end

   // Payload storage needs no reset; occupancy is tracked by the counters.
   always_ff @(posedge clk) begin
      for (int s = 0; s < Nsrc; s++) begin
         if (!rst && store[s]) begin
            opid_q[s][wptr_q[s]] <= bus.src_opid[s];
            prda_q[s][wptr_q[s]] <= bus.src_prda[s][Pw-1:0];
            prdv_q[s][wptr_q[s]] <= bus.src_prdv[s];
         end
      end
   end

   always_comb begin
      for (int s = 0; s < Nsrc; s++) begin
         bus.src_ready[s] = ~rst & (cnt_q[s] < (Aw+1)'(Depth));
      end
   end

   assign bus.exe_opid = exe_opid_q;
   assign bus.exe_prda = exe_prda_q;
   assign bus.exe_prdv = exe_prdv_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with redirects and resets.
module tb_wb_arbiter;
   localparam int NSRC = 4, EWD = 2, DEPTH = 4, PRNUM = 128, OPSZ = 16;

   typedef struct {
      logic [15:0] op;
      logic [15:0] pa;
      logic [63:0] pv;
      bit          k;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_arbiter_if #(.Nsrc(NSRC), .Ewd(EWD)) bus ();

   wb_arbiter #(
      .Nsrc(NSRC), .Ewd(EWD), .Depth(DEPTH), .Prnum(PRNUM), .Opsz(OPSZ)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int acc_cnt = 0;
   int out_cnt = 0;
   bit chk_en = 0;

   ent_t q[NSRC][$];
   int   rr = 0;
   logic [15:0] exp_op[EWD];
   logic [15:0] exp_pa[EWD];
   logic [63:0] exp_pv[EWD];

   task automatic check(string name, logic [63:0] got, logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic bit sq(logic [15:0] op);
      int o, r, t;
      o = int'(op) % OPSZ;
      r = int'(bus.red_opid) % OPSZ;
      t = int'(bus.red_topid) % OPSZ;
      return bus.red_opid[15] && op[15] && (((o - t + OPSZ) % OPSZ) >= ((r - t + 1 + OPSZ) % OPSZ));
   endfunction

   // Reference model: advances one cycle at each rising edge.
   initial begin
      for (int k = 0; k < EWD; k++) begin exp_op[k] = 0; exp_pa[k] = 0; exp_pv[k] = 0; end
      forever begin
         @(posedge clk);
         for (int k = 0; k < EWD; k++) begin exp_op[k] = 0; exp_pa[k] = 0; exp_pv[k] = 0; end
         if (rst) begin
            for (int s = 0; s < NSRC; s++) q[s].delete();
            rr = 0;
         end else begin
            bit rdy[NSRC];
            bit gnt[NSRC];
            int n, last;
            n = 0;
            last = -1;
            for (int s = 0; s < NSRC; s++) begin rdy[s] = q[s].size() < DEPTH; gnt[s] = 0; end
            for (int i = 0; i < NSRC; i++) begin
               int s;
               s = (rr + i) % NSRC;
               if (n < EWD && q[s].size() > 0 && !q[s][0].k && !sq(q[s][0].op)) begin
                  exp_op[n] = q[s][0].op; exp_pa[n] = q[s][0].pa; exp_pv[n] = q[s][0].pv;
                  n++;
                  gnt[s] = 1;
                  last = s;
               end
            end
            for (int s = 0; s < NSRC; s++)
               if (gnt[s] || (q[s].size() > 0 && q[s][0].k)) void'(q[s].pop_front());
            for (int s = 0; s < NSRC; s++)
               for (int e = 0; e < q[s].size(); e++)
                  if (sq(q[s][e].op)) q[s][e].k = 1;
            for (int s = 0; s < NSRC; s++) begin
               if (bus.src_valid[s] && rdy[s] && bus.src_opid[s][15] &&
                   bus.src_prda[s] != 0 && !sq(bus.src_opid[s])) begin
                  ent_t e;
                  e.op = bus.src_opid[s]; e.pa = bus.src_prda[s]; e.pv = bus.src_prdv[s]; e.k = 0;
                  q[s].push_back(e);
                  acc_cnt++;
               end
            end
            if (last >= 0) rr = (last + 1) % NSRC;
         end
      end
   end

   // Compare process: DUT against model on every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < EWD; k++) if (bus.exe_opid[k][15]) out_cnt++;
         if (chk_en) begin
            for (int k = 0; k < EWD; k++) begin
               check($sformatf("model_opid[%0d]", k), 64'(bus.exe_opid[k]), 64'(exp_op[k]));
               check($sformatf("model_prda[%0d]", k), 64'(bus.exe_prda[k]), 64'(exp_pa[k]));
               check($sformatf("model_prdv[%0d]", k), bus.exe_prdv[k], exp_pv[k]);
            end
            for (int s = 0; s < NSRC; s++)
               check($sformatf("model_ready[%0d]", s), 64'(bus.src_ready[s]),
                     64'(!rst && q[s].size() < DEPTH));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.src_valid = '0;
      bus.src_opid  = '0;
      bus.src_prda  = '0;
      bus.src_prdv  = '0;
      bus.red_opid  = '0;
      bus.red_topid = '0;
   endtask

   task automatic drive(int s, logic [15:0] op, logic [15:0] pa, logic [63:0] pv);
      bus.src_valid[s] = 1'b1;
      bus.src_opid[s]  = op;
      bus.src_prda[s]  = pa;
      bus.src_prdv[s]  = pv;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      bit saw_full;
      clear_in();
      rst = 1'b1;
      tick();
      chk_en = 1;
      check("rst_exe_opid0", 64'(bus.exe_opid[0]), 64'h0);
      check("rst_ready", 64'(bus.src_ready), 64'h0);
      tick();
      rst = 1'b0;
      #1;

      // Single result, two-cycle latency.
      drive(0, 16'h8003, 16'd5, 64'hDEAD);
      tick();
      clear_in();
      tick();
      check("t1_opid0", 64'(bus.exe_opid[0]), 64'h8003);
      check("t1_prda0", 64'(bus.exe_prda[0]), 64'd5);
      check("t1_prdv0", bus.exe_prdv[0], 64'hDEAD);
      check("t1_slot1_we", 64'(bus.exe_opid[1][15]), 64'h0);

      // Four simultaneous results drain two per cycle in round-robin order.
      do_reset();
      for (int s = 0; s < NSRC; s++) drive(s, 16'h8010 + 16'(s), 16'(s + 1), 64'(100 + s));
      tick();
      clear_in();
      tick();
      check("t2_c2_slot0", 64'(bus.exe_opid[0]), 64'h8010);
      check("t2_c2_slot1", 64'(bus.exe_opid[1]), 64'h8011);
      tick();
      check("t2_c3_slot0", 64'(bus.exe_opid[0]), 64'h8012);
      check("t2_c3_slot1", 64'(bus.exe_opid[1]), 64'h8013);
      tick();
      check("t2_c4_empty", 64'(bus.exe_opid[0][15]), 64'h0);

      // Redirect across ROB wrap: 0x800F survives, 0x8003 is squashed.
      drive(0, 16'h800F, 16'd9, 64'h0F);
      drive(1, 16'h8003, 16'd10, 64'h03);
      tick();
      clear_in();
      bus.red_opid  = 16'h8001;
      bus.red_topid = 16'h800E;
      tick();
      clear_in();
      check("t4_survivor", 64'(bus.exe_opid[0]), 64'h800F);
      check("t4_slot1_we", 64'(bus.exe_opid[1][15]), 64'h0);
      tick();
      check("t4_squashed0", 64'(bus.exe_opid[0][15]), 64'h0);
      check("t4_squashed1", 64'(bus.exe_opid[1][15]), 64'h0);

      // prda == 0 is accepted but never written.
      drive(2, 16'h8005, 16'd0, 64'h55);
      check("t5_ready", 64'(bus.src_ready[2]), 64'h1);
      tick();
      clear_in();
      tick();
      check("t5_no_write0", 64'(bus.exe_opid[0][15]), 64'h0);
      check("t5_no_write1", 64'(bus.exe_opid[1][15]), 64'h0);

      // Saturating pushes: ready must drop, and every accepted result must come out once.
      acc_cnt = 0;
      out_cnt = 0;
      saw_full = 0;
      for (int c = 0; c < 12; c++) begin
         for (int s = 0; s < NSRC; s++)
            drive(s, 16'h8000 | 16'((c * NSRC + s) % OPSZ), 16'(1 + s), 64'(1000 + c * NSRC + s));
         #1;
         if (bus.src_ready != 4'hF) saw_full = 1;
         tick();
      end
      clear_in();
      for (int c = 0; c < 14; c++) tick();
      check("t3_ready_drop", 64'(saw_full), 64'h1);
      check("t3_conservation", 64'(out_cnt), 64'(acc_cnt));

      // Reset drops buffered results.
      for (int s = 0; s < 3; s++) drive(s, 16'h8020 + 16'(s), 16'(7 + s), 64'(s));
      tick();
      clear_in();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("t6_exe_zero", 64'(bus.exe_opid[0] | bus.exe_opid[1]), 64'h0);
      check("t6_ready", 64'(bus.src_ready), 64'hF);
      tick();
      tick();
      check("t6_no_emerge", 64'(bus.exe_opid[0][15] | bus.exe_opid[1][15]), 64'h0);

      // Randomized traffic with redirects and occasional resets.
      for (int c = 0; c < 1500; c++) begin
         int rate;
         rate = ((c / 100) % 2 == 0) ? 3 : 1;
         clear_in();
         rst = ($urandom_range(0, 299) == 0);
         for (int s = 0; s < NSRC; s++) begin
            if ($urandom_range(0, 3) < rate) begin
               logic [15:0] op;
               logic [15:0] pa;
               op = 16'($urandom_range(0, 16'h7FFF));
               op[15] = ($urandom_range(0, 15) != 0);
               pa = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, PRNUM - 1));
               drive(s, op, pa, {32'(c), 32'(s)});
            end
         end
         if ($urandom_range(0, 19) == 0) begin
            bus.red_opid  = 16'h8000 | 16'($urandom_range(0, OPSZ - 1));
            bus.red_topid = 16'h8000 | 16'($urandom_range(0, OPSZ - 1));
         end
         tick();
      end
      clear_in();
      rst = 1'b0;
      for (int c = 0; c < 20; c++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
